conv1d_psum_collector: RTL and testbench

- Reader end of the conv1d PE chain. Consumes the psum stream leaving the last PE.
- Discards the NUM_TAPS-1 warm-up partial sums at the start of each row.
- Requantizes each kept psum to WIDTH_DATA bits: round, arithmetic shift, optional ReLU, saturate.
- Buffers the results in a small FIFO behind a valid/ready interface for the writeback stage, and signals row completion.

---
 rtl/conv1d_psum_collector.sv | 201 ++++++++++++++++++++
 tb/tb_conv1d_psum_collector.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/conv1d_psum_collector.sv
// Tail of the conv1d PE chain: drops warm-up psums, requantizes kept psums and
// queues them in a first-word-fall-through FIFO for the writeback stage.
module conv1d_psum_collector #(
    parameter int unsigned WIDTH_DATA = 8,
    parameter int unsigned PSUM_W     = 2 * WIDTH_DATA,
    parameter int unsigned NUM_TAPS   = 3,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [15:0]           cfg_len,
    input  logic [4:0]            cfg_shift,
    input  logic                  cfg_relu,
    input  logic                  psum_valid,
    input  logic [PSUM_W-1:0]     psum_in,
    output logic                  out_valid,
    output logic [WIDTH_DATA-1:0] out_data,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  ovf
);

    localparam int unsigned AW    = $clog2(FIFO_DEPTH);
    localparam int unsigned CW    = AW + 1;
    localparam int unsigned LEN_W = 16;
    localparam int unsigned SH_W  = 5;

    localparam logic signed [PSUM_W:0] SAT_MAX = (PSUM_W+1)'((1 << (WIDTH_DATA - 1)) - 1);
    localparam logic signed [PSUM_W:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WARMUP,
        S_COLLECT,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t                 state, next_state;
    logic [LEN_W-1:0]       warm_cnt, warm_cnt_d;
    logic [LEN_W-1:0]       kept_cnt, kept_cnt_d;
    logic [LEN_W-1:0]       len_q;
    logic [SH_W-1:0]        shift_q;
    logic                   relu_q;

    logic [WIDTH_DATA-1:0]  mem [FIFO_DEPTH];
    logic [AW-1:0]          rd_ptr, wr_ptr;
    logic [CW-1:0]          count, count_d;
    logic [WIDTH_DATA-1:0]  head_d;
    logic                   full, pop, push, drop;

    logic signed [PSUM_W:0] ext, rnd, rsum, shr;
    logic [WIDTH_DATA-1:0]  q_data;

    // Round half toward +inf, arithmetic shift, optional ReLU, saturate.
    always_comb begin
        ext = {psum_in[PSUM_W-1], psum_in};
        rnd = '0;
        if (shift_q != '0) begin
            rnd = (PSUM_W+1)'(1) << (shift_q - SH_W'(1));
        end
        rsum = ext + rnd;
        shr  = rsum >>> shift_q;
        if (relu_q && shr[PSUM_W]) begin
            shr = '0;
        end
        if (shr > SAT_MAX) begin
            q_data = WIDTH_DATA'(SAT_MAX);
        end else if (shr < SAT_MIN) begin
            q_data = WIDTH_DATA'(SAT_MIN);
        end else begin
            q_data = WIDTH_DATA'(shr);
        end
    end

    assign full = (count == CW'(FIFO_DEPTH));
    assign pop  = out_valid & out_ready;

    // Row sequencing: next state, counters and FIFO push/drop decisions.
    always_comb begin
        next_state = state;
        warm_cnt_d = warm_cnt;
        kept_cnt_d = kept_cnt;
        push       = 1'b0;
        drop       = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    warm_cnt_d = '0;
                    kept_cnt_d = '0;
                    if (cfg_len == '0) begin
                        next_state = S_DONE;
                    end else if (NUM_TAPS <= 1) begin
                        next_state = S_COLLECT;
                    end else begin
                        next_state = S_WARMUP;
                    end
                end
            end
            S_WARMUP: begin
                if (psum_valid) begin
                    warm_cnt_d = warm_cnt + LEN_W'(1);
                    if (warm_cnt == LEN_W'(NUM_TAPS - 2)) begin
                        next_state = S_COLLECT;
                    end
                end
            end
            S_COLLECT: begin
                if (psum_valid) begin
                    kept_cnt_d = kept_cnt + LEN_W'(1);
                    if (full && !pop) begin
                        drop = 1'b1;
                    end else begin
                        push = 1'b1;
                    end
                    if (kept_cnt_d == len_q) begin
                        next_state = S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
                if (count == '0) begin
                    next_state = S_DONE;
                end
            end
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Next FIFO head so out_data/out_valid can be registered.
    always_comb begin
        head_d  = out_data;
        count_d = count;
        if (push && !pop) begin
            count_d = count + CW'(1);
        end else if (!push && pop) begin
            count_d = count - CW'(1);
        end
        if (pop) begin
            if (count > CW'(1)) begin
                head_d = mem[AW'(rd_ptr + AW'(1))];
            end else if (push) begin
                head_d = q_data;
            end
        end else if (count == '0 && push) begin
            head_d = q_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            warm_cnt  <= '0;
            kept_cnt  <= '0;
            len_q     <= '0;
            shift_q   <= '0;
            relu_q    <= 1'b0;
            ovf       <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            count     <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            state    <= next_state;
            warm_cnt <= warm_cnt_d;
            kept_cnt <= kept_cnt_d;
            busy     <= (next_state != S_IDLE);
            done     <= (next_state == S_DONE);
            if (state == S_IDLE && start) begin
                len_q   <= cfg_len;
                shift_q <= cfg_shift;
                relu_q  <= cfg_relu;
                ovf     <= 1'b0;
            end else if (drop) begin
                ovf <= 1'b1;
            end
            if (push) begin
                wr_ptr <= AW'(wr_ptr + AW'(1));
            end
            if (pop) begin
                rd_ptr <= AW'(rd_ptr + AW'(1));
            end
            count     <= count_d;
            out_valid <= (count_d != '0);
            out_data  <= head_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= q_data;
        end
    end

endmodule

// File: tb/tb_conv1d_psum_collector.sv
// Directed and randomized checks of conv1d_psum_collector against a
// real-arithmetic requantization model and an expected-output queue.
module tb_conv1d_psum_collector;

    localparam int unsigned WD = 8;
    localparam int unsigned PW = 16;
    localparam int unsigned NT = 3;
    localparam int unsigned FD = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [15:0]   cfg_len;
    logic [4:0]    cfg_shift;
    logic          cfg_relu;
    logic          psum_valid;
    logic [PW-1:0] psum_in;
    logic          out_valid;
    logic [WD-1:0] out_data;
    logic          out_ready;
    logic          busy;
    logic          done;
    logic          ovf;

    int total = 0;
    int bad   = 0;
    int exp_q[$];

    int m_active = 0;
    int m_idx, m_kept, m_len, m_sh;
    bit m_relu;

    conv1d_psum_collector #(
        .WIDTH_DATA(WD), .PSUM_W(PW), .NUM_TAPS(NT), .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cfg_len(cfg_len),
        .cfg_shift(cfg_shift), .cfg_relu(cfg_relu), .psum_valid(psum_valid),
        .psum_in(psum_in), .out_valid(out_valid), .out_data(out_data),
        .out_ready(out_ready), .busy(busy), .done(done), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Round-half-up division by 2^sh, then ReLU and clamp to the output range.
    function automatic int rq(input int p, input int sh, input bit relu);
        real x;
        int  v;
        x = real'(p) / (2.0 ** sh);
        v = int'($floor(x + 0.5));
        if (relu && v < 0) v = 0;
        if (v > 127) v = 127;
        if (v < -128) v = -128;
        return v;
    endfunction

    // Every pop is checked against the head of the expected queue.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            check("out_pending", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                logic [7:0] e8;
                e8 = 8'(exp_q.pop_front());
                check("out_data", 32'(out_data), 32'(e8));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int len, input int sh, input bit relu);
        start     = 1'b1;
        cfg_len   = 16'(len);
        cfg_shift = 5'(sh);
        cfg_relu  = relu;
        cyc();
        start = 1'b0;
    endtask

    task automatic send(input int p);
        psum_valid = 1'b1;
        psum_in    = 16'(p);
        cyc();
        psum_valid = 1'b0;
    endtask

    task automatic send_m(input int p);
        if (m_active != 0) begin
            if (m_idx >= int'(NT) - 1 && m_kept < m_len) begin
                exp_q.push_back(rq(p, m_sh, m_relu));
                m_kept++;
            end
            m_idx++;
        end
        send(p);
    endtask

    task automatic wait_done(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            cyc();
            if (done === 1'b1) break;
        end
        check({tag, "_done"}, 32'(done), 32'd1);
        cyc();
        check({tag, "_done_clr"}, 32'(done), 32'd0);
        check({tag, "_busy_clr"}, 32'(busy), 32'd0);
        check({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; cfg_len = '0; cfg_shift = '0; cfg_relu = 1'b0;
        psum_valid = 1'b0; psum_in = '0; out_ready = 1'b1;
        cyc(); cyc();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        rst_n = 1'b1;
        cyc();

        // Basic row: warm-up drop, saturation, latency and done timing.
        exp_q = '{10, -3, 127, -128};
        do_start(4, 0, 0);
        check("basic_busy", 32'(busy), 32'd1);
        send(5); send(6);
        check("basic_warm_empty", 32'(out_valid), 32'd0);
        send(10);
        check("basic_lat_valid", 32'(out_valid), 32'd1);
        check("basic_lat_data", 32'(out_data), 32'd10);
        send(-3); send(200); send(-300);
        check("basic_last_valid", 32'(out_valid), 32'd1);
        cyc();
        check("basic_empty", 32'(out_valid), 32'd0);
        check("basic_no_early_done", 32'(done), 32'd0);
        cyc();
        check("basic_done", 32'(done), 32'd1);
        check("basic_busy_done", 32'(busy), 32'd1);
        cyc();
        check("basic_done_once", 32'(done), 32'd0);
        check("basic_busy_clr", 32'(busy), 32'd0);
        check("basic_drained", 32'(exp_q.size()), 32'd0);

        // Rounding without and with ReLU.
        exp_q = '{2, -1, 1};
        do_start(3, 2, 0);
        send(0); send(0); send(6); send(-6); send(5);
        wait_done("rnd", 20);
        exp_q = '{2, 0, 1};
        do_start(3, 2, 1);
        send(0); send(0); send(6); send(-6); send(5);
        wait_done("relu", 20);

        // Backpressure: 8 stored, 2 dropped, ovf sticky until next start.
        out_ready = 1'b0;
        do_start(10, 0, 0);
        send(0); send(0);
        for (int i = 1; i <= 10; i++) send(i);
        cyc();
        check("bp_ovf", 32'(ovf), 32'd1);
        check("bp_valid", 32'(out_valid), 32'd1);
        check("bp_busy", 32'(busy), 32'd1);
        cyc(); cyc();
        check("bp_flush_hold", 32'(done), 32'd0);
        check("bp_hold_data", 32'(out_data), 32'd1);
        for (int i = 1; i <= 8; i++) exp_q.push_back(i);
        out_ready = 1'b1;
        wait_done("bp", 40);
        check("bp_ovf_sticky", 32'(ovf), 32'd1);

        // Full FIFO with push and pop in the same cycle: nothing dropped.
        out_ready = 1'b0;
        do_start(9, 0, 0);
        check("full_ovf_cleared", 32'(ovf), 32'd0);
        send(0); send(0);
        for (int i = 21; i <= 28; i++) send(i);
        for (int i = 21; i <= 29; i++) exp_q.push_back(i);
        out_ready = 1'b1;
        send(29);
        check("full_ovf", 32'(ovf), 32'd0);
        check("full_head", 32'(out_data), 32'd22);
        wait_done("full", 40);
        check("full_ovf_end", 32'(ovf), 32'd0);

        // Zero length completes without output.
        do_start(0, 0, 0);
        check("zero_done", 32'(done), 32'd1);
        check("zero_no_out", 32'(out_valid), 32'd0);
        cyc();
        check("zero_done_clr", 32'(done), 32'd0);
        check("zero_busy_clr", 32'(busy), 32'd0);

        // Start while busy is ignored; cfg stays shift=0, relu=0, len=3.
        exp_q = '{-20, 7, 127};
        do_start(3, 0, 0);
        send(1);
        do_start(1, 4, 1);
        send(1);
        send(-20);
        do_start(1, 4, 1);
        send(7); send(300);
        wait_done("busy_start", 20);

        // Reset mid-COLLECT with 3 queued entries.
        out_ready = 1'b0;
        do_start(6, 0, 0);
        send(1); send(1); send(11); send(12); send(13);
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_ovf", 32'(ovf), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        cyc(); cyc();
        check("mid_rst_no_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        out_ready = 1'b1;
        cyc();
        exp_q = '{4, 5};
        do_start(2, 0, 0);
        send(0); send(0); send(4); send(5);
        wait_done("post_rst", 20);

        // Randomized rows against the reference model.
        for (int r = 0; r < 8; r++) begin
            m_len  = int'($urandom_range(1, 12));
            m_sh   = int'($urandom_range(0, 15));
            m_relu = 1'($urandom_range(0, 1));
            m_idx  = 0;
            m_kept = 0;
            m_active = 1;
            do_start(m_len, m_sh, m_relu);
            while (m_kept < m_len) begin
                send_m(int'($signed(16'($urandom))));
                if (m_kept < m_len) begin
                    for (int g = int'($urandom_range(0, 2)); g > 0; g--) cyc();
                end
            end
            m_active = 0;
            wait_done("rand", 40);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
